// File: rtl/recursive_mult_seq.sv
// Purpose: unsigned WIDTH x WIDTH multiply built from one time-shared (WIDTH/2)^2 sub-multiplier.
// Latency: product valid exactly 4 edges after the accept edge; initiation interval >= 5 cycles.
// Backpressure: product/out_valid held in DONE until out_ready; a new operand pair may be accepted on the same edge.
// Build option: define APPROX_LL_EN to truncate the low half of the AL*XL partial product.
module recursive_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     X,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int H  = WIDTH / 2;
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        step;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  x_q;
    logic [W2-1:0]     acc;

    logic [H-1:0]      op_a;
    logic [H-1:0]      op_x;
    logic [WIDTH-1:0]  pp;
    logic [WIDTH-1:0]  pp_term;
    logic [W2-1:0]     pp_shifted;
    logic [W2-1:0]     acc_next;
    logic              accept;

    // A transfer completes and a new one may start on the same edge in DONE.
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    // Operand-half selection for the single sub-multiplier: step bit 0 picks AH, bit 1 picks XH.
    always_comb begin
        op_a = step[0] ? a_q[WIDTH-1:H] : a_q[H-1:0];
        op_x = step[1] ? x_q[WIDTH-1:H] : x_q[H-1:0];
        pp   = WIDTH'(op_a) * WIDTH'(op_x);
    end

    // Partial-product conditioning: the LL term can be truncated in the approximate build.
    always_comb begin
        pp_term = pp;
`ifdef APPROX_LL_EN
        if (step == 2'd0) begin
            pp_term = {pp[WIDTH-1:H], {H{1'b0}}};
        end
`endif
    end

    // Align the partial product by its weight and accumulate modulo 2^(2*WIDTH).
    always_comb begin
        pp_shifted = '0;
        case (step)
            2'd0:    pp_shifted = W2'(pp_term);
            2'd1:    pp_shifted = W2'(pp_term) << H;
            2'd2:    pp_shifted = W2'(pp_term) << H;
            default: pp_shifted = W2'(pp_term) << (2 * H);
        endcase
        acc_next = acc + pp_shifted;
    end

    // Control FSM with registered out_valid/product; reset wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            a_q       <= '0;
            x_q       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= A;
                        x_q   <= X;
                        acc   <= '0;
                        step  <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        product   <= acc_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (accept) begin
                            a_q   <= A;
                            x_q   <= X;
                            acc   <= '0;
                            step  <= 2'd0;
                            state <= MUL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    step      <= 2'd0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
